// File: rtl/pipeline_ctrl_gen.sv
// Pipeline load-enable generator for the arithmetic-encoder datapath.
// Moves one occupancy token per symbol through NUM_STAGES registers with a programmable issue gap.
module pipeline_ctrl_gen #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned MAX_GAP    = 3,
  parameter int unsigned GAP_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset_ctrl,
  input  logic [GAP_W-1:0]      gap_cfg,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  out_valid,
  output logic [4:0]            inflight,
  output logic                  busy
);

  if (NUM_STAGES < 2 || NUM_STAGES > 16) begin : g_bad_stages
    $error("pipeline_ctrl_gen: NUM_STAGES must be in 2..16");
  end
  if ((64'd1 << GAP_W) <= 64'(MAX_GAP)) begin : g_bad_gap_w
    $error("pipeline_ctrl_gen: GAP_W too narrow to hold MAX_GAP");
  end

  localparam logic [GAP_W-1:0] MaxGapCfg = GAP_W'(MAX_GAP);

  logic [NUM_STAGES-1:0] occ_q, occ_d;
  logic [GAP_W-1:0]      cd_q, cd_d;
  logic                  out_valid_q, out_valid_d;

  logic                  advance;
  logic                  accept;
  logic [GAP_W-1:0]      gap_clamped;

  // Flush wins over stall; either one freezes every register enable.
  assign advance     = !stall && !flush;
  assign in_ready    = (cd_q == '0) && advance;
  assign accept      = in_valid && in_ready;
  assign gap_clamped = (gap_cfg > MaxGapCfg) ? MaxGapCfg : gap_cfg;

  assign stage_en = {occ_q[NUM_STAGES-2:0] & {(NUM_STAGES-1){advance}}, accept};

  always_comb begin
    occ_d       = occ_q;
    cd_d        = cd_q;
    out_valid_d = 1'b0;
    if (flush) begin
      occ_d = '0;
      cd_d  = '0;
    end else if (!stall) begin
      occ_d       = {occ_q[NUM_STAGES-2:0], accept};
      out_valid_d = occ_q[NUM_STAGES-2];
      // accept implies cd_q == 0, so reload and countdown never overlap.
      if (accept) begin
        cd_d = gap_clamped;
      end else if (cd_q != '0) begin
        cd_d = cd_q - GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset_ctrl) begin
    if (reset_ctrl) begin
      occ_q       <= '0;
      cd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      cd_q        <= cd_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      inflight = inflight + 5'(occ_q[i]);
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (occ_q != '0) || (cd_q != '0);

endmodule
